// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared widths, vector/id types and FSM states for the round-robin arbiter
package rr_arb_pkg;
  localparam int NUM_REQ = 8;
  localparam int ID_W = 3;
  typedef logic [NUM_REQ-1:0] req_vec_t;
  typedef logic [ID_W-1:0] req_id_t;
  typedef enum logic {IDLE, OWN} arb_state_t;
endpackage

// File: rtl/rr_prio_pick.sv
// rr_prio_pick: rotating-priority pick, searching last-1 downwards with wrap and last considered last
module rr_prio_pick
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    id,
  output logic               found
);
  logic [2*NUM_REQ-1:0] dbl;
  req_vec_t rot;
  req_id_t pos;
  assign dbl = {req, req} >> last;
  assign rot = dbl[NUM_REQ-1:0];
  // highest set bit of the rotated vector wins; bit 7 maps back to last-1, bit 0 to last
  always_comb begin
    pos = '0;
    for (int i = 0; i < NUM_REQ; i++) if (rot[i]) pos = req_id_t'(i);
  end
  assign id = pos + last;
  assign found = |req;
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter holding grants until release; RR_ARBITER8_TIMEOUT_EN adds bounded-hold preemption
module rr_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid
);
  arb_state_t state, state_nx;
  req_id_t last_id, last_nx, pick_last, win_id, id_nx;
  logic found, rearb, expire;
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be within 1..255");
  end
  assign pick_last = (state == OWN) ? grant_id : last_id;
  rr_prio_pick u_pick (.req(req), .last(pick_last), .id(win_id), .found(found));
`ifdef RR_ARBITER8_TIMEOUT_EN
  logic [7:0] hold, hold_nx;
  assign expire = hold == 8'(MAX_HOLD) && |(req & ~grant);
  // hold counter: load 1 on a new grant, count while kept, reload at the limit when nobody else waits
  always_comb hold_nx = rearb ? {7'd0, found} : (hold == 8'(MAX_HOLD) ? 8'd1 : hold + 8'd1);
  // hold counter register
  always_ff @(posedge clk) hold <= rst ? 8'd0 : hold_nx;
`else
  assign expire = 1'b0;
`endif
  // next state: re-arbitrate from idle, on owner release or on hold expiry, with the old owner searched last
  always_comb begin
    rearb = state == IDLE || !req[grant_id] || expire;
    state_nx = rearb ? (found ? OWN : IDLE) : state;
    id_nx = rearb ? (found ? win_id : '0) : grant_id;
    last_nx = (rearb && state == OWN) ? grant_id : last_id;
  end
  // state, last owner and registered grant outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_id <= '0;
      grant <= '0;
      grant_id <= '0;
      grant_valid <= 1'b0;
    end else begin
      state <= state_nx;
      last_id <= last_nx;
      grant <= (state_nx == OWN) ? req_vec_t'(1) << id_nx : '0;
      grant_id <= id_nx;
      grant_valid <= state_nx == OWN;
    end
  end
endmodule
